// File: rtl/reg_file_pkg.sv
// Shared RISC-V integer register file constants and types.
package reg_file_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file.sv
// Integer register file: x0 hardwired to zero, two combinational read ports,
// one synchronous write port, optional same-cycle write-to-read forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned       Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  // x0 has no storage; the array starts at index 1.
  logic [DATA_W-1:0] regs_q [1:Depth-1];

  logic write_ok;
  assign write_ok = we && (wa != ZeroAddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_ok) begin
      regs_q[wa] <= wd;
    end
  end

  // Forwarding is gated by rst_n so reads stay zero while reset is held.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] data;
    data = '0;
    if (ra != ZeroAddr) begin
      if (BYPASS && rst_n && write_ok && (wa == ra)) begin
        data = wd;
      end else begin
        data = regs_q[ra];
      end
    end
    return data;
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench: drives a BYPASS=0 and a BYPASS=1 register file in
// parallel and compares both against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

  logic [31:0] model [32];
  int n_checks;
  int n_fails;
  logic [127:0] got;
  logic [127:0] exp;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // Architectural view of a read: x0 is zero, a live write forwards only when
  // bypass is on and reset is released, otherwise the stored value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rst_n && we && (wa == a)) return wd;
    return model[a];
  endfunction

  function automatic logic [127:0] exp_all();
    return {exp_rd(ra1, 1'b0), exp_rd(ra2, 1'b0), exp_rd(ra1, 1'b1), exp_rd(ra2, 1'b1)};
  endfunction

  // Rising edge: commit the architectural write to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && (wa != 5'd0)) model[wa] = wd;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = $urandom | 32'd1;
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    clk_run = 1'b0;
    #1;
    rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      got = {rd1_0, rd2_0, rd1_1, rd2_1};
      exp = 128'd0;
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_clear addr=%0d: got %h want %h", i, got, exp);
      end
    end
    rst_n = 1'b1;
    #1;
    clk_run = 1'b1;
    tick();
  endtask

  task automatic test_alt_we();
    for (int i = 0; i < 32; i++) begin
      we = (i % 2 == 0); wa = 5'(i); wd = 32'(i);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ra1 = 5'(2 * k); ra2 = 5'(2 * k + 1);
      #1;
      got = {rd1_0, rd2_0, rd1_1, rd2_1};
      exp = {32'(2 * k), 32'd0, 32'(2 * k), 32'd0};
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL alt_we k=%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_x0();
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    we = 1'b0;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = 128'd0;
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL x0_protect: got %h want %h", got, exp);
    end
  endtask

  task automatic test_dual_port();
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
    tick();
    wa = 5'd6; wd = 32'hCAFE_F00D;
    tick();
    we = 1'b0;
    ra1 = 5'd5; ra2 = 5'd6;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = {32'h1234_5678, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL dual_read_5_6: got %h want %h", got, exp);
    end
    ra1 = 5'd6;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = {4{32'hCAFE_F00D}};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL dual_read_same: got %h want %h", got, exp);
    end
  endtask

  task automatic test_collision();
    we = 1'b1; wa = 5'd7; wd = 32'd1;
    tick();
    wd = 32'hA5A5_A5A5; ra1 = 5'd7; ra2 = 5'd6;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = {32'd1, 32'hCAFE_F00D, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL collision_pre_edge: got %h want %h", got, exp);
    end
    tick();
    we = 1'b0;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = {32'hA5A5_A5A5, 32'hCAFE_F00D, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL collision_post_edge: got %h want %h", got, exp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom);
      wa  = 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #1;
      got = {rd1_0, rd2_0, rd1_1, rd2_1};
      exp = exp_all();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL random n=%0d ra1=%0d ra2=%0d: got %h want %h", n, ra1, ra2, got, exp);
      end
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset_mid();
    we = 1'b1; wa = 5'd9; wd = 32'h1111_2222;
    tick();
    wd = 32'h5A5A_0F0F; ra1 = 5'd9; ra2 = 5'd7;
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = 128'd0;
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL reset_mid_asserted: got %h want %h", got, exp);
    end
    tick();
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = 128'd0;
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL reset_mid_x9: got %h want %h", got, exp);
    end
    we = 1'b1; wa = 5'd9; wd = 32'h0BAD_F00D;
    tick();
    we = 1'b0;
    #1;
    got = {rd1_0, rd2_0, rd1_1, rd2_1};
    exp = {32'h0BAD_F00D, 32'd0, 32'h0BAD_F00D, 32'd0};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL first_write_after_reset: got %h want %h", got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clk_run  = 1'b1;
    rst_n    = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_alt_we();
    test_x0();
    test_dual_port();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
